// File: rtl/pe_pkg.sv
// Shared definitions for the processing-element datapath: operating modes and format helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pe_pkg;

    // Operating modes selected by mode_i.
    typedef enum logic [1:0] {
        GEMM = 2'b00,
        DIV  = 2'b01,
        EXP  = 2'b10,
        LOG  = 2'b11
    } pe_mode_e;

    // Default fixed-point format of the operands: sign + integer + fraction bits.
    localparam int DEF_INT_BW = 5;
    localparam int DEF_FRA_BW = 7;
    localparam int DEF_MUL_BW = 16;
    localparam int DEF_ACC_BW = 32;

    // Operand width for a given integer/fraction split (sign bit included).
    function automatic int pe_op_bw(input int int_bw, input int fra_bw);
        return 1 + int_bw + fra_bw;
    endfunction

endpackage : pe_pkg

// File: rtl/pe_sat_mac.sv
// Signed multiply-add with saturation to the accumulator range: sum = sat(a*b + c).
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is captured.
module pe_sat_mac #(
    parameter int OP_BW  = 13,
    parameter int ACC_BW = 32
) (
    input  logic signed [OP_BW-1:0]  a_i,
    input  logic signed [OP_BW-1:0]  b_i,
    input  logic signed [ACC_BW-1:0] c_i,
    output logic signed [ACC_BW-1:0] sum_o,
    output logic                     sat_o
);

    localparam int PROD_BW = 2 * OP_BW;
    localparam int EXT_BW  = ACC_BW + 1;

    localparam logic signed [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};

    logic signed [PROD_BW-1:0] prod;
    logic signed [EXT_BW-1:0]  prod_x;
    logic signed [EXT_BW-1:0]  c_x;
    logic signed [EXT_BW-1:0]  sum_x;

    // Full-precision product and one guard bit on the addition so the sum itself never wraps.
    always_comb begin
        prod   = a_i * b_i;
        prod_x = {{(EXT_BW-PROD_BW){prod[PROD_BW-1]}}, prod};
        c_x    = {c_i[ACC_BW-1], c_i};
        sum_x  = prod_x + c_x;
    end

    // Guard bit disagreeing with the accumulator sign bit means the result left the range.
    always_comb begin
        sat_o = 1'b0;
        sum_o = sum_x[ACC_BW-1:0];
        if (sum_x[EXT_BW-1] != sum_x[ACC_BW-1]) begin
            sat_o = 1'b1;
            sum_o = sum_x[EXT_BW-1] ? ACC_MIN : ACC_MAX;
        end
    end

endmodule : pe_sat_mac

// File: rtl/pe_m_gen.sv
// Processing element: streams x/var/wc through registers and multiply-accumulates into oreg.
// Latency: one cycle from a valid beat to valid_o and the updated oreg.
// Backpressure: none; valid_i=0 stalls the element and every data register holds.
module pe_m_gen
    import pe_pkg::*;
#(
    parameter int INT_BW = DEF_INT_BW,
    parameter int FRA_BW = DEF_FRA_BW,
    parameter int MUL_BW = DEF_MUL_BW,
    parameter int ACC_BW = DEF_ACC_BW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               mode_i,
    input  logic                     acc_sel_i,
    input  logic                     clr_i,
    input  logic                     valid_i,
    input  logic signed [ACC_BW-1:0] mac_i,
    input  logic signed [MUL_BW-1:0] var_i,
    input  logic signed [MUL_BW-1:0] x_i,
    input  logic signed [MUL_BW-1:0] wc_i,
    input  logic signed [ACC_BW-1:0] o_i,
    output logic                     valid_o,
    output logic                     sat_o,
    output logic signed [ACC_BW-1:0] mac_o,
    output logic signed [MUL_BW-1:0] var_o,
    output logic signed [MUL_BW-1:0] x_o,
    output logic signed [MUL_BW-1:0] wc_o,
    output logic signed [ACC_BW-1:0] o_o
);

    localparam int OP_BW  = pe_op_bw(INT_BW, FRA_BW);
    // Top bit of the integer part of a full-precision (2*FRA_BW fraction) product.
    localparam int MAC_HI = INT_BW + 2 * FRA_BW;

    // Range of mac_i that converts to the operand format without clamping.
    localparam logic signed [ACC_BW-1:0] MAC_MAX = ACC_BW'((64'sd1 <<< MAC_HI) - 64'sd1);
    localparam logic signed [ACC_BW-1:0] MAC_MIN = ~MAC_MAX;

    localparam logic signed [OP_BW-1:0] OP_MAX = {1'b0, {(OP_BW-1){1'b1}}};
    localparam logic signed [OP_BW-1:0] OP_MIN = {1'b1, {(OP_BW-1){1'b0}}};

    // Architectural state.
    logic signed [OP_BW-1:0]  wreg_q, wreg_d;
    logic signed [MUL_BW-1:0] ireg_q, ireg_d;
    logic signed [MUL_BW-1:0] vreg_q, vreg_d;
    logic signed [ACC_BW-1:0] oreg_q, oreg_d;
    logic                     sat_q,  sat_d;
    logic                     vld_q,  vld_d;

    // Datapath signals.
    pe_mode_e                 mode;
    logic signed [OP_BW-1:0]  mac_t;
    logic signed [OP_BW-1:0]  op_a;
    logic signed [OP_BW-1:0]  op_b;
    logic signed [ACC_BW-1:0] op_c;
    logic signed [ACC_BW-1:0] wreg_acc_x;
    logic signed [ACC_BW-1:0] mac_sum;
    logic                     mac_sat;

    // Only the low OP_BW bits of the weight bus carry the operand.
    logic unused_wc_hi;
    assign unused_wc_hi = ^wc_i[MUL_BW-1:OP_BW];

    assign mode       = pe_mode_e'(mode_i);
    assign wreg_acc_x = {{(ACC_BW-OP_BW){wreg_q[OP_BW-1]}}, wreg_q};

    // Convert the incoming accumulator value to operand format, clamping out-of-range values.
    always_comb begin
        mac_t = mac_i[MAC_HI:FRA_BW];
        if (mac_i > MAC_MAX) begin
            mac_t = OP_MAX;
        end else if (mac_i < MAC_MIN) begin
            mac_t = OP_MIN;
        end
    end

    // Operand selection from pre-edge register values; mode and acc_sel act immediately.
    always_comb begin
        op_a = wreg_q;
        op_b = ireg_q[MUL_BW-1:MUL_BW-OP_BW];
        op_c = acc_sel_i ? oreg_q : o_i;
        if (mode != GEMM) begin
            op_a = mac_t;
            op_b = vreg_q[MUL_BW-1:MUL_BW-OP_BW];
            op_c = wreg_acc_x;
        end
    end

    pe_sat_mac #(
        .OP_BW  (OP_BW),
        .ACC_BW (ACC_BW)
    ) u_sat_mac (
        .a_i   (op_a),
        .b_i   (op_b),
        .c_i   (op_c),
        .sum_o (mac_sum),
        .sat_o (mac_sat)
    );

    // Next state: capture on valid beats, hold otherwise; clear overrides the accumulator only.
    always_comb begin
        wreg_d = wreg_q;
        ireg_d = ireg_q;
        vreg_d = vreg_q;
        oreg_d = oreg_q;
        sat_d  = sat_q;
        vld_d  = valid_i;
        if (valid_i) begin
            wreg_d = wc_i[OP_BW-1:0];
            ireg_d = x_i;
            vreg_d = var_i;
            oreg_d = mac_sum;
            sat_d  = sat_q | mac_sat;
        end
        if (clr_i) begin
            oreg_d = '0;
            sat_d  = 1'b0;
        end
    end

    // State registers; reset drops any in-flight accumulation immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wreg_q <= '0;
            ireg_q <= '0;
            vreg_q <= '0;
            oreg_q <= '0;
            sat_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            wreg_q <= wreg_d;
            ireg_q <= ireg_d;
            vreg_q <= vreg_d;
            oreg_q <= oreg_d;
            sat_q  <= sat_d;
            vld_q  <= vld_d;
        end
    end

    assign wc_o    = {{(MUL_BW-OP_BW){wreg_q[OP_BW-1]}}, wreg_q};
    assign x_o     = ireg_q;
    assign var_o   = vreg_q;
    assign mac_o   = oreg_q;
    assign o_o     = oreg_q;
    assign sat_o   = sat_q;
    assign valid_o = vld_q;

endmodule : pe_m_gen
